capture_path_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the two-register capture datapath (d1/d2/en into the buffer/inverter/AND/OR cone feeding two DFFs) between two requesters. It drives the datapath inputs for exactly one cycle per grant, samples the register outputs after the capture edge, and returns the result to the winning requester with a one-cycle ack. An optional cooldown separates consecutive transactions. It sits between the requester logic and the capture datapath on the same clock.

---
 rtl/capture_path_arbiter.sv | 122 ++++++++++++
 tb/tb_capture_path_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_path_arbiter.sv
// rtl/capture_path_arbiter.sv - round-robin sequencer sharing the two-register capture datapath
module capture_path_arbiter #(
   parameter int HOLD_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] din0,
   input  logic [1:0] din1,
   output logic       d1,
   output logic       d2,
   output logic       en,
   input  logic       q1,
   input  logic       q2,
   output logic [1:0] ack,
   output logic [1:0] rdata,
   output logic       busy,
   output logic [7:0] grant_cnt
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, COOL} state_t;

   // Cooldown reload value; COOL lasts HOLD_CYCLES cycles counting down to zero.
   localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'((HOLD_CYCLES > 0) ? (HOLD_CYCLES - 1) : 0);
   localparam bit               HAS_COOL = (HOLD_CYCLES > 0);

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             winner_q, winner_d;
   logic             d1_d, d2_d, en_d;
   logic [1:0]       ack_d, rdata_d;
   logic [7:0]       grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       eligible;
   logic             pick;

   // State and registered outputs; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         winner_q  <= 1'b0;
         d1        <= 1'b0;
         d2        <= 1'b0;
         en        <= 1'b0;
         ack       <= 2'b00;
         rdata     <= 2'b00;
         grant_cnt <= 8'd0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         winner_q  <= winner_d;
         d1        <= d1_d;
         d2        <= d2_d;
         en        <= en_d;
         ack       <= ack_d;
         rdata     <= rdata_d;
         grant_cnt <= grant_d;
         cnt_q     <= cnt_d;
      end
   end

   // Next-state and next-output logic; datapath drives are zero outside DRIVE.
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      winner_d = winner_q;
      d1_d     = 1'b0;
      d2_d     = 1'b0;
      en_d     = 1'b0;
      ack_d    = 2'b00;
      rdata_d  = rdata;
      grant_d  = grant_cnt;
      cnt_d    = cnt_q;
      // A requester still holding req during its ack cycle is not re-granted.
      eligible = req & ~ack;
      pick     = (eligible == 2'b11) ? ~last_q : eligible[1];

      case (state_q)
         IDLE: begin
            if (eligible != 2'b00) begin
               winner_d     = pick;
               last_d       = pick;
               {d2_d, d1_d} = pick ? din1 : din0;
               en_d         = 1'b1;
               state_d      = DRIVE;
            end
         end
         DRIVE: begin
            state_d = SAMPLE;
         end
         SAMPLE: begin
            rdata_d = {q2, q1};
            ack_d   = winner_q ? 2'b10 : 2'b01;
            if (grant_cnt != 8'hFF) begin
               grant_d = grant_cnt + 8'd1;
            end
            if (HAS_COOL) begin
               cnt_d   = HOLD_M1;
               state_d = COOL;
            end else begin
               state_d = IDLE;
            end
         end
         COOL: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_capture_path_arbiter.sv
// tb/tb_capture_path_arbiter.sv - directed self-checking bench for capture_path_arbiter
module tb_capture_path_arbiter;

   logic       clk;
   logic       rst_n;
   logic [1:0] din0, din1;

   // Instance A: HOLD_CYCLES = 2
   logic [1:0] reqa, acka, rdataa;
   logic       d1a, d2a, ena, q1a, q2a, busya;
   logic [7:0] gcnta;

   // Instance B: HOLD_CYCLES = 0
   logic [1:0] reqb, ackb, rdatab;
   logic       d1b, d2b, enb, q1b, q2b, busyb;
   logic [7:0] gcntb;

   int tests_run;
   int tests_failed;

   capture_path_arbiter #(.HOLD_CYCLES(2), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req(reqa), .din0(din0), .din1(din1),
      .d1(d1a), .d2(d2a), .en(ena), .q1(q1a), .q2(q2a),
      .ack(acka), .rdata(rdataa), .busy(busya), .grant_cnt(gcnta)
   );

   capture_path_arbiter #(.HOLD_CYCLES(0), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req(reqb), .din0(din0), .din1(din1),
      .d1(d1b), .d2(d2b), .en(enb), .q1(q1b), .q2(q2b),
      .ack(ackb), .rdata(rdatab), .busy(busyb), .grant_cnt(gcntb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath model: buffer/inverter/AND/OR cone into two DFFs.
   initial begin
      q1a = 1'b0; q2a = 1'b0; q1b = 1'b0; q2b = 1'b0;
   end
   always @(posedge clk) begin
      q1a <= ~d1a & ena;
      q2a <= d2a | (~d1a & ena);
      q1b <= ~d1b & enb;
      q2b <= d2b | (~d1b & enb);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      tests_run++;
      if ({d1a, d2a, ena, acka, rdataa, busya} !== 7'b0 || gcnta !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_a got d1d2en=%b%b%b ack=%b rdata=%b busy=%b cnt=%0d exp all 0",
                  d1a, d2a, ena, acka, rdataa, busya, gcnta);
      end
      tests_run++;
      if ({d1b, d2b, enb, ackb, rdatab, busyb} !== 7'b0 || gcntb !== 8'd0) begin
         tests_failed++;
         $display("FAIL reset_b got d1d2en=%b%b%b ack=%b rdata=%b busy=%b cnt=%0d exp all 0",
                  d1b, d2b, enb, ackb, rdatab, busyb, gcntb);
      end
   endtask

   task automatic test_single_req0;
      din0 = 2'b00;
      reqa = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         tests_run++;
         if (ena !== (k == 1)) begin
            tests_failed++;
            $display("FAIL single0_en k=%0d got %b exp %b", k, ena, (k == 1));
         end
         tests_run++;
         if (busya !== (k >= 1 && k <= 4)) begin
            tests_failed++;
            $display("FAIL single0_busy k=%0d got %b exp %b", k, busya, (k <= 4));
         end
         tests_run++;
         if (acka !== ((k == 3) ? 2'b01 : 2'b00)) begin
            tests_failed++;
            $display("FAIL single0_ack k=%0d got %b exp %b", k, acka, ((k == 3) ? 2'b01 : 2'b00));
         end
         if (k == 3) begin
            tests_run++;
            if (rdataa !== 2'b11 || gcnta !== 8'd1) begin
               tests_failed++;
               $display("FAIL single0_data got rdata=%b cnt=%0d exp rdata=11 cnt=1", rdataa, gcnta);
            end
            reqa = 2'b00;
         end
      end
   endtask

   task automatic test_single_req1;
      logic [1:0] vin  [2];
      logic [1:0] vexp [2];
      vin[0] = 2'b11; vexp[0] = 2'b10;
      vin[1] = 2'b01; vexp[1] = 2'b00;
      for (int v = 0; v < 2; v++) begin
         din1 = vin[v];
         reqa = 2'b10;
         for (int k = 1; k <= 5; k++) begin
            tick(1);
            tests_run++;
            if (ena !== (k == 1)) begin
               tests_failed++;
               $display("FAIL single1_en v=%0d k=%0d got %b exp %b", v, k, ena, (k == 1));
            end
            tests_run++;
            if (acka !== ((k == 3) ? 2'b10 : 2'b00)) begin
               tests_failed++;
               $display("FAIL single1_ack v=%0d k=%0d got %b exp %b", v, k, acka, ((k == 3) ? 2'b10 : 2'b00));
            end
            if (k == 3) begin
               tests_run++;
               if (rdataa !== vexp[v] || gcnta !== 8'(2 + v)) begin
                  tests_failed++;
                  $display("FAIL single1_data v=%0d got rdata=%b cnt=%0d exp rdata=%b cnt=%0d",
                           v, rdataa, gcnta, vexp[v], 2 + v);
               end
               reqa = 2'b00;
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] eack;
      logic       een;
      din0 = 2'b00;
      din1 = 2'b01;
      reqa = 2'b11;
      for (int k = 1; k <= 14; k++) begin
         tick(1);
         eack = (k == 3 || k == 13) ? 2'b01 : ((k == 8) ? 2'b10 : 2'b00);
         een  = (k == 1 || k == 6 || k == 11);
         tests_run++;
         if (acka !== eack) begin
            tests_failed++;
            $display("FAIL b2b_ack k=%0d got %b exp %b", k, acka, eack);
         end
         tests_run++;
         if (ena !== een) begin
            tests_failed++;
            $display("FAIL b2b_en k=%0d got %b exp %b", k, ena, een);
         end
         if (k == 3 || k == 8) begin
            tests_run++;
            if (rdataa !== ((k == 3) ? 2'b11 : 2'b00)) begin
               tests_failed++;
               $display("FAIL b2b_rdata k=%0d got %b exp %b", k, rdataa, ((k == 3) ? 2'b11 : 2'b00));
            end
         end
         if (k == 13) reqa = 2'b00;
      end
      tick(1);
   endtask

   task automatic test_hold0;
      din0 = 2'b10;
      din1 = 2'b11;
      reqb = 2'b01;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         tests_run++;
         if (enb !== (k == 1)) begin
            tests_failed++;
            $display("FAIL hold0_en k=%0d got %b exp %b", k, enb, (k == 1));
         end
         tests_run++;
         if (ackb !== ((k == 3) ? 2'b01 : 2'b00)) begin
            tests_failed++;
            $display("FAIL hold0_ack k=%0d got %b exp %b", k, ackb, ((k == 3) ? 2'b01 : 2'b00));
         end
         if (k == 3) begin
            tests_run++;
            if (rdatab !== 2'b11 || busyb !== 1'b0) begin
               tests_failed++;
               $display("FAIL hold0_data got rdata=%b busy=%b exp rdata=11 busy=0", rdatab, busyb);
            end
         end
         if (k == 4) reqb = 2'b00;
      end
      reqb = 2'b11;
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         tests_run++;
         if (enb !== (k == 1)) begin
            tests_failed++;
            $display("FAIL hold0_rr_en k=%0d got %b exp %b", k, enb, (k == 1));
         end
         tests_run++;
         if (ackb !== ((k == 3) ? 2'b10 : 2'b00)) begin
            tests_failed++;
            $display("FAIL hold0_rr_ack k=%0d got %b exp %b", k, ackb, ((k == 3) ? 2'b10 : 2'b00));
         end
         if (k == 3) begin
            tests_run++;
            if (rdatab !== 2'b10) begin
               tests_failed++;
               $display("FAIL hold0_rr_rdata got %b exp 10", rdatab);
            end
            reqb = 2'b00;
         end
      end
   endtask

   task automatic test_reset_mid;
      din0 = 2'b00;
      reqa = 2'b01;
      tick(1);
      tests_run++;
      if (ena !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_drive got en=%b exp 1", ena);
      end
      tick(1);
      rst_n = 1'b0;
      reqa  = 2'b00;
      tick(1);
      tests_run++;
      if (acka !== 2'b00 || rdataa !== 2'b00 || gcnta !== 8'd0 || busya !== 1'b0 || ena !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_abort got ack=%b rdata=%b cnt=%0d busy=%b en=%b exp 00 00 0 0 0",
                  acka, rdataa, gcnta, busya, ena);
      end
      rst_n = 1'b1;
      tick(1);
      din1 = 2'b11;
      reqa = 2'b10;
      for (int k = 1; k <= 5; k++) begin
         tick(1);
         tests_run++;
         if (acka !== ((k == 3) ? 2'b10 : 2'b00)) begin
            tests_failed++;
            $display("FAIL rstmid_fresh_ack k=%0d got %b exp %b", k, acka, ((k == 3) ? 2'b10 : 2'b00));
         end
         if (k == 3) begin
            tests_run++;
            if (rdataa !== 2'b10 || gcnta !== 8'd1) begin
               tests_failed++;
               $display("FAIL rstmid_fresh_data got rdata=%b cnt=%0d exp rdata=10 cnt=1", rdataa, gcnta);
            end
            reqa = 2'b00;
         end
      end
   endtask

   task automatic test_saturate;
      reqb = 2'b11;
      tick(300);
      tests_run++;
      if (gcntb !== 8'd100) begin
         tests_failed++;
         $display("FAIL sat_mid got cnt=%0d exp 100", gcntb);
      end
      tick(500);
      tests_run++;
      if (gcntb !== 8'd255) begin
         tests_failed++;
         $display("FAIL sat_cap got cnt=%0d exp 255", gcntb);
      end
      reqb = 2'b00;
      tick(4);
      tests_run++;
      if (gcntb !== 8'd255 || busyb !== 1'b0) begin
         tests_failed++;
         $display("FAIL sat_hold got cnt=%0d busy=%b exp 255 0", gcntb, busyb);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      reqa  = 2'b00;
      reqb  = 2'b00;
      din0  = 2'b00;
      din1  = 2'b00;
      tick(3);
      test_reset;
      rst_n = 1'b1;
      tick(1);
      test_single_req0;
      test_single_req1;
      test_back_to_back;
      test_hold0;
      test_reset_mid;
      test_saturate;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
